// File: rtl/wb_dma_qpwr_ctrl.sv
// Q-channel power-down sequencer: idle detect -> quiesce handshake -> clock gate -> wake/exit.
// Outputs decode from the state register or come straight from flops; optional watchdog under WB_DMA_QPWR_TIMEOUT_EN.
// No backpressure: device responses are waited for indefinitely and wake events act on the next edge.
module wb_dma_qpwr_ctrl #(
  parameter int NDEV    = 2,
  parameter int IDLE_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic [IDLE_W-1:0] idle_thresh_i,
  input  logic [NDEV-1:0]   wake_i,
  input  logic [NDEV-1:0]   qacceptn_i,
  input  logic [NDEV-1:0]   qdeny_i,
  output logic [NDEV-1:0]   qreqn_o,
  output logic              clk_en_o,
  output logic              stopped_o,
  output logic [7:0]        deny_cnt_o,
  output logic [2:0]        state_o,
  output logic              err_o
);

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    REQ     = 3'd1,
    STOPPED = 3'd2,
    EXIT    = 3'd3,
    DENY    = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [7:0]        deny_cnt;
  logic              any_wake, all_acc, any_deny, all_up, idle_go;

  assign any_wake = |wake_i;
  assign all_acc  = ~|qacceptn_i;
  assign any_deny = |qdeny_i;
  assign all_up   = &qacceptn_i;
  assign idle_go  = (idle_cnt >= idle_thresh_i) && !any_wake && en_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= EXIT;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (idle_go) state_nxt = REQ;
      // deny wins over a simultaneous full accept; wake is ignored until a response arrives
      REQ:     if (any_deny) state_nxt = DENY;
               else if (all_acc) state_nxt = STOPPED;
      STOPPED: if (any_wake || !en_i) state_nxt = EXIT;
      EXIT:    if (all_up) state_nxt = RUN;
      DENY:    if (!any_deny && all_up) state_nxt = RUN;
      default: state_nxt = EXIT;
    endcase
  end

  always_comb begin
    qreqn_o   = (state == REQ || state == STOPPED) ? '0 : '1;
    clk_en_o  = (state != STOPPED);
    stopped_o = (state == STOPPED);
    state_o   = state;
  end

  // Idle count only lives in RUN, so every re-entry to RUN starts from zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idle_cnt <= '0;
    end else if (state == RUN && !any_wake && en_i) begin
      if (idle_cnt != '1) idle_cnt <= idle_cnt + 1'b1;
    end else begin
      idle_cnt <= '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                          deny_cnt <= '0;
    else if (state == REQ && any_deny && deny_cnt != 8'hFF) deny_cnt <= deny_cnt + 8'd1;
  end

  assign deny_cnt_o = deny_cnt;

`ifdef WB_DMA_QPWR_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            err_q;
  logic            wd_active;

  assign wd_active = (state == REQ || state == EXIT || state == DENY) && (state_nxt == state);

  // Flags only; the FSM keeps waiting so the handshake stays legal.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (!wd_active)                      wd_cnt <= '0;
      else if (wd_cnt != WD_W'(TIMEOUT))   wd_cnt <= wd_cnt + 1'b1;
      if (wd_active && wd_cnt == WD_W'(TIMEOUT - 1)) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  logic [31:0] timeout_unused;
  assign timeout_unused = TIMEOUT;
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_dma_qpwr_ctrl.sv
// Bench for wb_dma_qpwr_ctrl: directed vector table, hand sequences, then random stimulus vs a reference model.
module tb_wb_dma_qpwr_ctrl;
  localparam int NDEV = 2;
  localparam int IDLE_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic [IDLE_W-1:0] thresh = '0;
  logic [NDEV-1:0]  wake = '0, qacc = '0, qdeny = '0;
  logic [NDEV-1:0]  qreqn;
  logic             clk_en, stopped, err;
  logic [7:0]       deny_cnt;
  logic [2:0]       state;

  int total = 0;
  int bad = 0;

  // reference model: mode follows the spec's named states by number
  int m_mode = 3;
  int m_idle = 0;
  int m_deny = 0;

  typedef struct {
    logic       en;
    logic [7:0] th;
    logic [1:0] w, a, d;
    logic [2:0] st;
    logic [1:0] qr;
    logic       ce, sp;
    logic [7:0] dc;
  } vec_t;

  vec_t tbl[$];

  wb_dma_qpwr_ctrl #(.NDEV(NDEV), .IDLE_W(IDLE_W), .TIMEOUT(64)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .idle_thresh_i(thresh),
    .wake_i(wake), .qacceptn_i(qacc), .qdeny_i(qdeny),
    .qreqn_o(qreqn), .clk_en_o(clk_en), .stopped_o(stopped),
    .deny_cnt_o(deny_cnt), .state_o(state), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic e, input logic [7:0] th, input logic [1:0] w, input logic [1:0] a,
                     input logic [1:0] d, input logic [2:0] st, input logic [1:0] qr,
                     input logic ce, input logic sp, input logic [7:0] dc);
    vec_t v;
    v.en = e; v.th = th; v.w = w; v.a = a; v.d = d;
    v.st = st; v.qr = qr; v.ce = ce; v.sp = sp; v.dc = dc;
    tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_step();
    bit wk;
    wk = (wake != '0);
    if (m_mode != 0) m_idle = 0;
    case (m_mode)
      0: if (wk || !en) m_idle = 0;
         else begin
           if (m_idle >= int'(thresh)) m_mode = 1;
           m_idle = (m_idle < 255) ? m_idle + 1 : 255;
         end
      1: if (qdeny != '0) begin
           m_mode = 4;
           if (m_deny < 255) m_deny++;
         end else if (qacc == '0) m_mode = 2;
      2: if (wk || !en) m_mode = 3;
      3: if (qacc == '1) m_mode = 0;
      4: if (qdeny == '0 && qacc == '1) m_mode = 0;
      default: m_mode = 3;
    endcase
  endtask

  function automatic logic [14:0] model_out();
    logic [1:0] qr;
    qr = (m_mode == 1 || m_mode == 2) ? 2'b00 : 2'b11;
    return {3'(m_mode), qr, (m_mode != 2), (m_mode == 2), 8'(m_deny)};
  endfunction

  initial begin
    // idle detect with threshold 4, then a stop/wake round trip
    add(1, 4, 2'b01, 2'b00, 2'b00, 3, 2'b11, 1, 0, 0);
    add(1, 4, 2'b01, 2'b00, 2'b00, 3, 2'b11, 1, 0, 0);
    add(1, 4, 2'b01, 2'b11, 2'b00, 0, 2'b11, 1, 0, 0);
    add(1, 4, 2'b01, 2'b11, 2'b00, 0, 2'b11, 1, 0, 0);
    for (int i = 0; i < 4; i++) add(1, 4, 2'b00, 2'b11, 2'b00, 0, 2'b11, 1, 0, 0);
    add(1, 4, 2'b00, 2'b11, 2'b00, 1, 2'b00, 1, 0, 0);
    add(1, 4, 2'b00, 2'b11, 2'b00, 1, 2'b00, 1, 0, 0);
    add(1, 4, 2'b11, 2'b11, 2'b00, 1, 2'b00, 1, 0, 0);
    add(1, 4, 2'b00, 2'b00, 2'b00, 2, 2'b00, 0, 1, 0);
    add(1, 4, 2'b10, 2'b00, 2'b00, 3, 2'b11, 1, 0, 0);
    add(1, 4, 2'b00, 2'b01, 2'b00, 3, 2'b11, 1, 0, 0);
    add(1, 4, 2'b00, 2'b11, 2'b00, 0, 2'b11, 1, 0, 0);
    // partial accept plus deny, device 0 must reopen before RUN
    for (int i = 0; i < 4; i++) add(1, 4, 2'b00, 2'b11, 2'b00, 0, 2'b11, 1, 0, 0);
    add(1, 4, 2'b00, 2'b11, 2'b00, 1, 2'b00, 1, 0, 0);
    add(1, 4, 2'b00, 2'b10, 2'b10, 4, 2'b11, 1, 0, 1);
    add(1, 4, 2'b00, 2'b10, 2'b00, 4, 2'b11, 1, 0, 1);
    add(1, 4, 2'b00, 2'b11, 2'b00, 0, 2'b11, 1, 0, 1);
    // threshold 0, deny beats simultaneous full accept
    add(1, 0, 2'b00, 2'b11, 2'b00, 1, 2'b00, 1, 0, 1);
    add(1, 0, 2'b00, 2'b00, 2'b01, 4, 2'b11, 1, 0, 2);
    add(1, 0, 2'b00, 2'b11, 2'b00, 0, 2'b11, 1, 0, 2);
    // en low blocks requests; en falling in REQ lets the handshake finish
    add(0, 0, 2'b00, 2'b11, 2'b00, 0, 2'b11, 1, 0, 2);
    add(0, 0, 2'b00, 2'b11, 2'b00, 0, 2'b11, 1, 0, 2);
    add(1, 0, 2'b00, 2'b11, 2'b00, 1, 2'b00, 1, 0, 2);
    add(0, 0, 2'b00, 2'b11, 2'b00, 1, 2'b00, 1, 0, 2);
    add(0, 0, 2'b00, 2'b00, 2'b00, 2, 2'b00, 0, 1, 2);
    add(0, 0, 2'b00, 2'b00, 2'b00, 3, 2'b11, 1, 0, 2);
    add(1, 200, 2'b00, 2'b11, 2'b00, 0, 2'b11, 1, 0, 2);
    // threshold lowered mid-count takes effect at once
    add(1, 200, 2'b00, 2'b11, 2'b00, 0, 2'b11, 1, 0, 2);
    add(1, 200, 2'b00, 2'b11, 2'b00, 0, 2'b11, 1, 0, 2);
    add(1, 2, 2'b00, 2'b11, 2'b00, 1, 2'b00, 1, 0, 2);
    add(1, 2, 2'b00, 2'b00, 2'b00, 2, 2'b00, 0, 1, 2);
    add(1, 2, 2'b00, 2'b00, 2'b00, 2, 2'b00, 0, 1, 2);
    add(1, 2, 2'b01, 2'b00, 2'b00, 3, 2'b11, 1, 0, 2);
    add(1, 2, 2'b01, 2'b11, 2'b00, 0, 2'b11, 1, 0, 2);

    en = 1'b0; qacc = 2'b00; wake = 2'b01; thresh = 8'd4;
    #12;
    cmp("reset_state", 32'(state), 32'd3);
    cmp("reset_qreqn", 32'(qreqn), 32'h3);
    cmp("reset_clk_en", 32'(clk_en), 32'd1);
    cmp("reset_stopped", 32'(stopped), 32'd0);
    cmp("reset_deny_cnt", 32'(deny_cnt), 32'd0);
    cmp("reset_err", 32'(err), 32'd0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      en = tbl[i].en; thresh = tbl[i].th; wake = tbl[i].w; qacc = tbl[i].a; qdeny = tbl[i].d;
      tick();
      cmp($sformatf("vec%0d_state", i), 32'(state), 32'(tbl[i].st));
      cmp($sformatf("vec%0d_qreqn", i), 32'(qreqn), 32'(tbl[i].qr));
      cmp($sformatf("vec%0d_clk_en", i), 32'(clk_en), 32'(tbl[i].ce));
      cmp($sformatf("vec%0d_stopped", i), 32'(stopped), 32'(tbl[i].sp));
      cmp($sformatf("vec%0d_deny_cnt", i), 32'(deny_cnt), 32'(tbl[i].dc));
    end

    // 256 denies with wake held during REQ; count must pin at 255
    en = 1'b1; thresh = 8'd0;
    for (int i = 0; i < 256; i++) begin
      wake = 2'b00; qacc = 2'b11; qdeny = 2'b00;
      tick();
      wake = 2'b11;
      tick();
      cmp("req_wake_hold_state", 32'(state), 32'd1);
      cmp("req_wake_hold_qreqn", 32'(qreqn), 32'h0);
      wake = 2'b00; qdeny = 2'b01;
      tick();
      cmp("deny_state", 32'(state), 32'd4);
      qdeny = 2'b00;
      tick();
    end
    cmp("deny_cnt_sat", 32'(deny_cnt), 32'd255);

    // async reset in the middle of a handshake
    wake = 2'b00; qacc = 2'b11; qdeny = 2'b00;
    tick();
    cmp("pre_reset_req", 32'(state), 32'd1);
    rst_n = 1'b0;
    #2;
    cmp("midreset_state", 32'(state), 32'd3);
    cmp("midreset_qreqn", 32'(qreqn), 32'h3);
    cmp("midreset_deny_cnt", 32'(deny_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    m_mode = 3; m_idle = 0; m_deny = 0;

    for (int c = 0; c < 4000; c++) begin
      en     = ($urandom_range(0, 15) != 0);
      thresh = 8'($urandom_range(0, 6));
      wake   = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
      if ($urandom_range(0, 3) == 0) qacc = 2'($urandom);
      else qacc = (m_mode == 1 || m_mode == 2) ? 2'b00 : 2'b11;
      qdeny  = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00;
      model_step();
      tick();
      cmp($sformatf("rand%0d {st,qr,ce,sp,dc}", c),
          32'({state, qreqn, clk_en, stopped, deny_cnt}), 32'(model_out()));
    end
`ifndef WB_DMA_QPWR_TIMEOUT_EN
    cmp("err_tied_low", 32'(err), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_dma_qpwr_ctrl.md
Name: wb_dma_qpwr_ctrl

Overview:
Power-down sequencer for one or more Q-channel-wrapped DMA instances sharing a clock domain.
- Watches bus/DMA activity and waits for a programmable idle period.
- Then drives a Q-channel quiesce handshake (qreqn/qacceptn/qdeny) to every device and gates their clock once all accept.
- On any wake event it restores the clock and brings every device back to RUN.
- Sits between the system clock/activity fabric and the wb_dma Q-channel wrappers.

Parameters:
NDEV, 2, number of Q-channel devices controlled (1..8)
IDLE_W, 8, width of idle counter and idle_thresh_i
TIMEOUT, 64, handshake watchdog limit in cycles (optional feature only)

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
en_i  input  1  auto power-down enable; 0 = never request quiesce
idle_thresh_i  input  IDLE_W  idle cycles required before request
wake_i  input  NDEV  per-device activity (cyc/dma_req OR), any bit = wake
qacceptn_i  input  NDEV  device accept, active-low
qdeny_i  input  NDEV  device deny
qreqn_o  output  NDEV  quiesce request, active-low, same value on all bits
clk_en_o  output  1  clock-gate enable for the controlled devices
stopped_o  output  1  high while in STOPPED
deny_cnt_o  output  8  saturating count of denied requests
state_o  output  3  current state encoding
err_o  output  1  sticky handshake timeout (optional feature; else tied 0)

Behaviour:
- Reset is async assert, sync deassert at the consumer. Reset values: state=EXIT, qreqn_o=all 1, clk_en_o=1, stopped_o=0, deny_cnt_o=0, idle counter=0, err_o=0.
- All outputs are registered or decoded from the state register only; no input-to-output combinational paths.
- State encoding: RUN=0, REQ=1, STOPPED=2, EXIT=3, DENY=4.
- The anyacc/allacc/anydeny/allup terms below are computed over all NDEV bits.
- RUN:
  - qreqn_o=1.
  - idle_cnt increments each cycle with wake_i==0 && en_i, saturating at all-ones. It clears on any wake or !en_i.
  - Transition: idle_cnt>=idle_thresh_i && wake_i==0 && en_i -> REQ.
  - With threshold T, qreqn_o falls after T+1 consecutive idle cycles plus 1 register cycle.
- REQ:
  - qreqn_o=0.
  - wake_i is ignored: qreqn must not rise before a response.
  - any qdeny_i=1 -> DENY; deny takes priority over simultaneous full accept. deny_cnt increments, saturating at 255.
  - else all qacceptn_i==0 -> STOPPED.
- STOPPED:
  - qreqn_o=0, clk_en_o=0 (registered, low from the first STOPPED cycle), stopped_o=1.
  - any wake_i or !en_i -> EXIT. clk_en_o returns to 1 in the same edge.
- EXIT:
  - qreqn_o=1, clk_en_o=1.
  - all qacceptn_i==1 -> RUN.
  - A wake during EXIT has no effect.
- DENY:
  - qreqn_o=1.
  - all qdeny_i==0 && all qacceptn_i==1 -> RUN; idle_cnt restarts at 0.
  - Devices that had already accepted must reopen before RUN.
- en_i falling in REQ does not abort the request; the handshake completes, then STOPPED->EXIT follows next cycle.
- Reset mid-handshake returns to EXIT with qreqn_o=1; devices still in STOP see the re-entry request.
- idle_thresh_i is sampled every cycle; a change mid-count uses the new value immediately.

Optional Feature:
WB_DMA_QPWR_TIMEOUT_EN:
- Defined: a watchdog counter runs in REQ, EXIT and DENY and clears on each state change. If it reaches TIMEOUT, err_o sets and stays set until reset. The FSM does not change state, preserving protocol legality.
- Undefined: no counter; err_o tied 0.

Test Plan:
- Reset with qacceptn_i=all 0, then set all qacceptn_i=1 at cycle 3 -> qreqn_o=all 1 throughout, state_o=3 until cycle 4, then 0; clk_en_o=1.
- RUN, idle_thresh_i=4, en_i=1, wake_i drops to 0 -> qreqn_o falls after 5 idle cycles +1. Devices pull qacceptn_i low 2 cycles later -> stopped_o=1, clk_en_o=0 the next cycle.
- STOPPED, wake_i[1]=1 for 1 cycle -> clk_en_o=1 and qreqn_o=all 1 next cycle. State stays EXIT until all qacceptn_i=1, then RUN.
- REQ, device 0 accepts, device 1 raises qdeny_i=1 -> state DENY, qreqn_o=all 1, deny_cnt_o=1. RUN once qdeny_i=0 and qacceptn_i=all 1.
- 256 successive denies -> deny_cnt_o saturates at 255. wake_i=1 throughout REQ does not raise qreqn_o before the response.
- WB_DMA_QPWR_TIMEOUT_EN defined, TIMEOUT=64, REQ with no response -> err_o=1 at cycle 64 and stays 1; state_o remains 1. Macro undefined -> err_o=0.
